// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly
// forward key expansion. Returns the ciphertext together with the round-10
// key, so the decrypt side's last-round key can be loaded straight from here.
module aes128_enc_iter #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic [127:0] key_last
);

  if (ROUNDS != 10) begin : g_rounds_check
    $error("aes128_enc_iter supports only ROUNDS = 10");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX[idx*8 +: 8];
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte n of the state sits at bits [127-8n -: 8]; byte n = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*((c + w) % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the AES-128 key schedule (RotWord, SubWord, Rcon).
  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot, tmp, w0, w1, w2, w3;
    rot = {k[23:0], k[31:24]};
    tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rc, 24'h000000};
    w0  = k[127:96] ^ tmp;
    w1  = k[95:64]  ^ w0;
    w2  = k[63:32]  ^ w1;
    w3  = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [1:0]   state;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   rnd;
  logic [127:0] next_rk;
  logic [127:0] round_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Round datapath: next round key and next state; the final round skips MixColumns.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_rk   = key_exp(rk, rcon(rnd));
    round_out = shift_rows(sub_bytes(st));
    if (rnd != LAST_RND) round_out = mix_columns(round_out);
    round_out = round_out ^ next_rk;
  end

  // Control FSM plus state, round-key and result registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state    <= IDLE;
      st       <= '0;
      rk       <= '0;
      rnd      <= '0;
      dout     <= '0;
      key_last <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= data ^ key;
            rk    <= key;
            rnd   <= 4'd1;
            state <= ROUND;
          end
        end
        ROUND: begin
          st  <= round_out;
          rk  <= next_rk;
          rnd <= rnd + 4'd1;
          if (rnd == LAST_RND) begin
            dout     <= round_out;
            key_last <= next_rk;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: FIPS-197 vectors from a table,
// then backpressure, back-to-back and mid-round reset sequences.
module tb_aes128_enc_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic [127:0] key_last;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] exp_dout;
    logic [127:0] exp_key;
  } vec_t;

  vec_t vecs[3];

  aes128_enc_iter #(.ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .key_last  (key_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    in_valid = 1'($urandom);
    data     = {$urandom, $urandom, $urandom, $urandom};
    key      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Present one request, measure latency, check the result and complete the handshake.
  task automatic run_block(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready before accept"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    data     = v.data;
    key      = v.key;
    @(negedge clk);
    in_valid = 1'b0;
    data     = '0;
    key      = '0;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'd10);
    check({tag, " dout"}, dout, v.exp_dout);
    check({tag, " key_last"}, key_last, v.exp_key);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 128'(out_valid), 128'd0);
    check({tag, " in_ready after handshake"}, 128'(in_ready), 128'd1);
    check({tag, " dout held after handshake"}, dout, v.exp_dout);
  endtask

  initial begin
    logic [127:0] res[2];
    int           acc[2];
    int           res_cyc[2];
    int           accepts;
    int           results;
    int           lat;

    vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2] = '{128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data      = '0;
    key       = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset dout", dout, 128'd0);
    check("reset key_last", key_last, 128'd0);
    rst = 1'b0;

    // Table-driven known-answer vectors.
    for (int i = 0; i < 3; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with inputs toggling during ROUND and DONE.
    @(negedge clk);
    in_valid = 1'b1;
    data     = vecs[0].data;
    key      = vecs[0].key;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("bp in_ready during rounds", 128'(in_ready), 128'd0);
      scramble_inputs();
      @(negedge clk);
      lat++;
    end
    check("bp latency", 128'(lat), 128'd10);
    for (int i = 0; i < 20; i++) begin
      check("bp out_valid held", 128'(out_valid), 128'd1);
      check("bp in_ready held low", 128'(in_ready), 128'd0);
      check("bp dout stable", dout, vecs[0].exp_dout);
      check("bp key_last stable", key_last, vecs[0].exp_key);
      scramble_inputs();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp out_valid after release", 128'(out_valid), 128'd0);
    check("bp in_ready after release", 128'(in_ready), 128'd1);
    check("bp dout kept", dout, vecs[0].exp_dout);
    check("bp key_last kept", key_last, vecs[0].exp_key);

    // Back-to-back: App. B then App. C.1 with both handshakes always ready.
    out_ready = 1'b1;
    accepts   = 0;
    results   = 0;
    acc[0] = 0; acc[1] = 0; res_cyc[0] = 0; res_cyc[1] = 0;
    res[0] = '0; res[1] = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid && results < 2) begin
        res[results]     = dout;
        res_cyc[results] = c;
        results++;
      end
      if (in_ready) begin
        if (accepts < 2) begin
          acc[accepts] = c;
          in_valid     = 1'b1;
          data         = vecs[accepts].data;
          key          = vecs[accepts].key;
          accepts++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b accept count", 128'(accepts), 128'd2);
    check("b2b result count", 128'(results), 128'd2);
    check("b2b accept spacing", 128'(acc[1] - acc[0]), 128'd12);
    check("b2b first latency", 128'(res_cyc[0] - acc[0]), 128'd11);
    check("b2b second latency", 128'(res_cyc[1] - acc[1]), 128'd11);
    check("b2b first dout", res[0], vecs[0].exp_dout);
    check("b2b second dout", res[1], vecs[1].exp_dout);

    // Reset asserted between edges while round 5 is being computed.
    @(negedge clk);
    in_valid = 1'b1;
    data     = vecs[0].data;
    key      = vecs[0].key;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid reset out_valid", 128'(out_valid), 128'd0);
    check("mid reset in_ready", 128'(in_ready), 128'd1);
    check("mid reset dout", dout, 128'd0);
    check("mid reset key_last", key_last, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block(vecs[0], "post-reset vec0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
